// File: rtl/snake_pkg.sv
// snake_pkg: shared direction/state types and the reversal helper for the snake engine
package snake_pkg;
  typedef enum logic [1:0] {LEFT = 2'b00, RIGHT = 2'b01, DOWN = 2'b10, UP = 2'b11} dir_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READY, S_MOVE, S_CHECK, S_DRAW, S_DEAD} state_t;
  // LEFT/RIGHT and DOWN/UP differ only in bit 0
  function automatic dir_t opposite(dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction
endpackage

// File: rtl/snake_body_engine_if.sv
// snake_body_engine_if: valid/ready segment stream from the engine to the pixel plotter
interface snake_body_engine_if #(parameter int XW = 8, parameter int YW = 7);
  logic valid, ready, last;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  modport master(output valid, x, y, last, input ready);
  modport slave(input valid, x, y, last, output ready);
endinterface

// File: rtl/snake_seg_ring.sv
// snake_seg_ring: body ring buffer, head pushed at head_ptr-1, tail popped, reads indexed from the head
module snake_seg_ring #(
  parameter int MAX_LEN = 128,
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int PW = 7
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             push_head,
  input  logic             pop_tail,
  input  logic [XW+YW-1:0] wr_data,
  input  logic [PW-1:0]    rd_idx,
  output logic [XW+YW-1:0] rd_data
);
  localparam logic [PW-1:0] LAST = PW'(MAX_LEN - 1);
  localparam logic [PW:0] DEPTH = (PW+1)'(MAX_LEN);
  logic [XW+YW-1:0] mem [MAX_LEN];
  logic [PW-1:0] head_ptr, tail_ptr, head_new;
  logic [PW:0] rd_sum;
  assign head_new = head_ptr == '0 ? LAST : head_ptr - 1'b1;
  assign rd_sum = {1'b0, head_ptr} + {1'b0, rd_idx};
  // explicit wrap so non-power-of-two depths index correctly
  assign rd_data = mem[rd_sum >= DEPTH ? PW'(rd_sum - DEPTH) : rd_sum[PW-1:0]];
  // pointer update; an empty ring has the tail one slot behind the head
  always_ff @(posedge clk or negedge resetn)
    if (!resetn || clear) begin
      head_ptr <= '0;
      tail_ptr <= LAST;
    end else begin
      if (push_head) head_ptr <= head_new;
      if (pop_tail) tail_ptr <= tail_ptr == '0 ? LAST : tail_ptr - 1'b1;
    end
  // segment storage, contents are don't-care after reset
  always_ff @(posedge clk)
    if (push_head && !clear) mem[head_new] <= wr_data;
endmodule

// File: rtl/snake_body_engine.sv
// snake_body_engine: snake body core (move, grow, collide, stream head-first); SNAKE_WRAP_EN makes the field wrap instead of killing at walls
module snake_body_engine import snake_pkg::*; #(
  parameter int GRID_W   = 160,
  parameter int GRID_H   = 120,
  parameter int MAX_LEN  = 128,
  parameter int INIT_LEN = 3,
  parameter int START_X  = 30,
  parameter int START_Y  = 20,
  parameter int WALL     = 2,
  parameter int XW = $clog2(GRID_W),
  parameter int YW = $clog2(GRID_H),
  parameter int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          mv_left,
  input  logic          mv_right,
  input  logic          mv_down,
  input  logic          mv_up,
  input  logic          step,
  input  logic [XW-1:0] apple_x,
  input  logic [YW-1:0] apple_y,
  input  logic          draw_req,
  snake_body_engine_if.master seg,
  output logic          step_done,
  output logic          ate,
  output logic          dead,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic          busy
);
  localparam int PW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam logic [LW-1:0] ONE_L = 1;
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);
  localparam logic [LW-1:0] INIT_L = LW'(INIT_LEN);
  localparam logic [XW-1:0] SX = XW'(START_X);
  localparam logic [YW-1:0] SY = YW'(START_Y);
  localparam logic [XW:0] X1 = 1;
  localparam logic [YW:0] Y1 = 1;
  state_t state;
  dir_t dir, last_dir, btn_dir;
  logic [LW-1:0] idx;
  logic hit, ate_pend, wall_hit, eat, push, pop, match, mv_any;
  logic [XW:0] nx_w;
  logic [YW:0] ny_w;
  logic [XW-1:0] nx, rd_x;
  logic [YW-1:0] ny, rd_y;
  logic [XW+YW-1:0] wr_data, rd_data;
  logic [PW-1:0] rd_idx;
  assign mv_any = mv_left | mv_right | mv_down | mv_up;
  assign btn_dir = mv_left ? LEFT : mv_right ? RIGHT : mv_down ? DOWN : UP;
  // one extra bit so stepping off either edge is visible as out of range
  assign nx_w = dir == LEFT ? {1'b0, head_x} - X1 : dir == RIGHT ? {1'b0, head_x} + X1 : {1'b0, head_x};
  assign ny_w = dir == UP ? {1'b0, head_y} - Y1 : dir == DOWN ? {1'b0, head_y} + Y1 : {1'b0, head_y};
`ifdef SNAKE_WRAP_EN
  localparam logic [XW:0] XMAX = (XW+1)'(GRID_W - 1);
  localparam logic [YW:0] YMAX = (YW+1)'(GRID_H - 1);
  assign nx = nx_w > XMAX ? (dir == LEFT ? XMAX[XW-1:0] : '0) : nx_w[XW-1:0];
  assign ny = ny_w > YMAX ? (dir == UP ? YMAX[YW-1:0] : '0) : ny_w[YW-1:0];
  assign wall_hit = 1'b0;
`else
  localparam logic [XW:0] XLO = (XW+1)'(WALL);
  localparam logic [XW:0] XHI = (XW+1)'(GRID_W - WALL - 1);
  localparam logic [YW:0] YLO = (YW+1)'(WALL);
  localparam logic [YW:0] YHI = (YW+1)'(GRID_H - WALL - 1);
  assign nx = nx_w[XW-1:0];
  assign ny = ny_w[YW-1:0];
  assign wall_hit = nx_w < XLO || nx_w > XHI || ny_w < YLO || ny_w > YHI;
`endif
  assign eat = nx == apple_x && ny == apple_y;
  assign push = !start && (state == S_LOAD || (state == S_MOVE && !wall_hit));
  // at full length an apple still costs the tail, so the ring never overflows
  assign pop = !start && state == S_MOVE && !wall_hit && (!eat || length == MAX_L);
  assign wr_data = state == S_LOAD ? {SX + XW'(idx), SY} : {nx, ny};
  // DRAW looks one segment ahead so the next one is ready on transfer
  assign rd_idx = PW'(state == S_DRAW ? idx + ONE_L : idx);
  assign {rd_x, rd_y} = rd_data;
  assign match = rd_data == {head_x, head_y};
  assign busy = !(state == S_READY || state == S_IDLE || state == S_DEAD);
  snake_seg_ring #(.MAX_LEN(MAX_LEN), .XW(XW), .YW(YW), .PW(PW)) u_ring (
    .clk(clk),
    .resetn(resetn),
    .clear(start),
    .push_head(push),
    .pop_tail(pop),
    .wr_data(wr_data),
    .rd_idx(rd_idx),
    .rd_data(rd_data)
  );
  // engine FSM: initial load, move/check sequencing, segment stream and direction latch
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= S_IDLE;
      dir <= LEFT;
      last_dir <= LEFT;
      idx <= '0;
      hit <= 1'b0;
      ate_pend <= 1'b0;
      step_done <= 1'b0;
      ate <= 1'b0;
      dead <= 1'b0;
      head_x <= '0;
      head_y <= '0;
      length <= '0;
      seg.valid <= 1'b0;
      seg.last <= 1'b0;
      seg.x <= '0;
      seg.y <= '0;
    end else begin
      step_done <= 1'b0;
      ate <= 1'b0;
      if (mv_any && btn_dir != opposite(last_dir)) dir <= btn_dir;
      if (start) begin
        state <= S_LOAD;
        idx <= LW'(INIT_LEN - 1);
        dead <= 1'b0;
        dir <= LEFT;
        last_dir <= LEFT;
        seg.valid <= 1'b0;
        seg.last <= 1'b0;
      end else
        case (state)
          S_LOAD: begin
            dir <= LEFT;
            if (idx == '0) begin
              state <= S_READY;
              length <= INIT_L;
              head_x <= SX;
              head_y <= SY;
            end else idx <= idx - ONE_L;
          end
          S_READY:
            if (step) state <= S_MOVE;
            else if (draw_req) begin
              state <= S_DRAW;
              seg.valid <= 1'b1;
              seg.x <= rd_x;
              seg.y <= rd_y;
              seg.last <= length == ONE_L;
            end
          S_MOVE: begin
            last_dir <= dir;
            if (wall_hit) begin
              state <= S_DEAD;
              dead <= 1'b1;
              step_done <= 1'b1;
            end else begin
              head_x <= nx;
              head_y <= ny;
              ate_pend <= eat;
              if (eat && length != MAX_L) length <= length + ONE_L;
              idx <= ONE_L;
              hit <= 1'b0;
              state <= S_CHECK;
            end
          end
          S_CHECK:
            if (idx == length - ONE_L) begin
              step_done <= 1'b1;
              ate <= ate_pend;
              dead <= hit | match;
              state <= hit | match ? S_DEAD : S_READY;
              idx <= '0;
            end else begin
              hit <= hit | match;
              idx <= idx + ONE_L;
            end
          S_DRAW:
            if (seg.ready) begin
              if (seg.last) begin
                seg.valid <= 1'b0;
                seg.last <= 1'b0;
                state <= S_READY;
                idx <= '0;
              end else begin
                seg.x <= rd_x;
                seg.y <= rd_y;
                seg.last <= idx + ONE_L == length - ONE_L;
                idx <= idx + ONE_L;
              end
            end
          S_IDLE, S_DEAD: ;
          default: state <= S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_snake_body_engine.sv
// tb_snake_body_engine: step table with a cell model plus a segment scoreboard for the draw stream
module tb_snake_body_engine;
  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic last;
  } seg_t;
  typedef struct {
    int x;
    int y;
  } cell_t;
  typedef struct {
    bit st;
    logic [3:0] b1, b2;
    bit wd;
    int ax, ay, hx, hy, len;
    bit ate, dead;
    int drw;
  } row_t;
  logic clk = 0, resetn = 0, start = 0, step = 0, draw_req = 0;
  logic mv_left = 0, mv_right = 0, mv_down = 0, mv_up = 0;
  logic [7:0] apple_x = 8'd100, head_x, length;
  logic [6:0] apple_y = 7'd100, head_y;
  logic step_done, ate, dead, busy;
  int checks = 0, errors = 0;
  seg_t exp_q[$];
  cell_t body[$];
  row_t rows[9];
  logic [15:0] cur, held;
  bit hv = 0;
  seg_t e;
  snake_body_engine_if #(.XW(8), .YW(7)) sif ();
  snake_body_engine dut (
    .clk(clk), .resetn(resetn), .start(start),
    .mv_left(mv_left), .mv_right(mv_right), .mv_down(mv_down), .mv_up(mv_up),
    .step(step), .apple_x(apple_x), .apple_y(apple_y), .draw_req(draw_req),
    .seg(sif), .step_done(step_done), .ate(ate), .dead(dead),
    .head_x(head_x), .head_y(head_y), .length(length), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask
  // segment monitor: transfers are popped from the scoreboard, stalled segments must hold
  initial forever begin
    @(negedge clk);
    #1;
    cur = {sif.x, sif.y, sif.last};
    if (hv && sif.valid) check("seg_hold", cur, held);
    if (sif.valid && sif.ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL seg_extra got %0h expected none", cur);
      end else begin
        e = exp_q.pop_front();
        check("seg", cur, {e.x, e.y, e.last});
      end
    end
    hv = sif.valid && !sif.ready;
    held = cur;
  end
  task automatic press(input logic [3:0] b);
    {mv_left, mv_right, mv_down, mv_up} = b;
    @(negedge clk);
    {mv_left, mv_right, mv_down, mv_up} = 4'b0;
  endtask
  task automatic do_draw(input bit tog);
    int n = 0;
    for (int i = 0; i < body.size(); i++)
      exp_q.push_back('{8'(body[i].x), 7'(body[i].y), i == body.size() - 1});
    draw_req = 1;
    sif.ready = !tog;
    do begin
      @(negedge clk);
      draw_req = 0;
      sif.ready = tog ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end while ((exp_q.size() != 0 || sif.valid) && n < 300);
    sif.ready = 1;
    check("draw_drained", exp_q.size(), 0);
    check("draw_busy", busy, 0);
    exp_q.delete();
  endtask
  task automatic do_start(input bit drw);
    int n = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("start_len", length, 3);
    check("start_head", {head_x, head_y}, {8'd30, 7'd20});
    check("start_dead", dead, 0);
    body.delete();
    for (int i = 0; i < 3; i++) body.push_back('{30 + i, 20});
    if (drw) do_draw(0);
  endtask
  task automatic do_step(input bit wd, output int lat, output logic ate_s);
    step = 1;
    draw_req = wd;
    lat = 0;
    do begin
      @(negedge clk);
      step = 0;
      draw_req = 0;
      lat++;
    end while (!step_done && lat < 300);
    ate_s = ate;
    @(negedge clk);
    check("done_pulse", step_done, 0);
  endtask
  initial begin
    int lat;
    logic a;
    sif.ready = 1;
    rows[0] = '{1, 4'b0000, 4'b0000, 0, 100, 100, 29, 20, 3, 0, 0, 1};
    rows[1] = '{0, 4'b0100, 4'b0000, 1, 100, 100, 28, 20, 3, 0, 0, 0};
    rows[2] = '{0, 4'b0001, 4'b0100, 0, 100, 100, 28, 19, 3, 0, 0, 0};
    rows[3] = '{0, 4'b0000, 4'b0000, 0, 28, 18, 28, 18, 4, 1, 0, 2};
    rows[4] = '{1, 4'b0000, 4'b0000, 0, 29, 20, 29, 20, 4, 1, 0, 0};
    rows[5] = '{0, 4'b0000, 4'b0000, 0, 28, 20, 28, 20, 5, 1, 0, 1};
    rows[6] = '{0, 4'b0001, 4'b0000, 0, 100, 100, 28, 19, 5, 0, 0, 0};
    rows[7] = '{0, 4'b0100, 4'b0000, 0, 100, 100, 29, 19, 5, 0, 0, 0};
    rows[8] = '{0, 4'b0010, 4'b0000, 0, 100, 100, 29, 20, 5, 0, 1, 0};
    repeat (3) @(negedge clk);
    resetn = 1;
    @(negedge clk);
    check("rst_outs", {sif.valid, step_done, ate, dead, busy}, 0);
    check("rst_len", length, 0);
    check("rst_head", {head_x, head_y}, 0);
    foreach (rows[r]) begin
      if (rows[r].st) do_start(1);
      apple_x = 8'(rows[r].ax);
      apple_y = 7'(rows[r].ay);
      if (rows[r].b1 != 0) press(rows[r].b1);
      if (rows[r].b2 != 0) press(rows[r].b2);
      do_step(rows[r].wd, lat, a);
      check($sformatf("r%0d_latency", r), lat, rows[r].len + 1);
      check($sformatf("r%0d_head", r), {head_x, head_y}, {8'(rows[r].hx), 7'(rows[r].hy)});
      check($sformatf("r%0d_len", r), length, rows[r].len);
      check($sformatf("r%0d_ate", r), a, rows[r].ate);
      check($sformatf("r%0d_dead", r), dead, rows[r].dead);
      if (rows[r].wd) check("step_over_draw", sif.valid, 0);
      body.push_front('{rows[r].hx, rows[r].hy});
      while (body.size() > rows[r].len) void'(body.pop_back());
      if (rows[r].drw != 0) do_draw(rows[r].drw == 2);
    end
    do_start(0);
    apple_x = 8'd100;
    apple_y = 7'd100;
`ifdef SNAKE_WRAP_EN
    for (int i = 1; i <= 31; i++) begin
      do_step(0, lat, a);
      check($sformatf("wrap_x%0d", i), head_x, i == 31 ? 159 : 30 - i);
    end
    check("wrap_alive", dead, 0);
    check("wrap_latency", lat, 4);
`else
    for (int i = 1; i <= 28; i++) begin
      do_step(0, lat, a);
      check($sformatf("wall_x%0d", i), head_x, 30 - i);
    end
    check("wall_alive", dead, 0);
    do_step(0, lat, a);
    check("wall_latency", lat, 2);
    check("wall_dead", dead, 1);
    check("wall_head", {head_x, head_y}, {8'd2, 7'd20});
    step = 1;
    draw_req = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("dead_ignores", {step_done, sif.valid, busy}, 0);
    end
    step = 0;
    draw_req = 0;
    check("dead_held", dead, 1);
`endif
    do_start(0);
    sif.ready = 0;
    draw_req = 1;
    repeat (3) @(negedge clk);
    draw_req = 0;
    check("stall_valid", {sif.valid, sif.x, sif.y}, {1'b1, 8'd30, 7'd20});
    start = 1;
    @(negedge clk);
    start = 0;
    check("abort_valid", sif.valid, 0);
    sif.ready = 1;
    repeat (5) @(negedge clk);
    check("abort_len", length, 3);
    check("abort_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
